// File: rtl/mem_responder_pkg.sv
// Shared rv32i memory-interface types for the mem_responder slice: word/mask
// types, responder FSM states and the captured-request payload.
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mem_wmask;

  localparam int unsigned MEM_LATENCY_MAX = 15;
  localparam int unsigned MEM_CNT_W       = $clog2(MEM_LATENCY_MAX + 1);

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_RESP
  } mem_resp_state_t;

  // Request fields latched at acceptance; write wins when both opcodes are set
  typedef struct packed {
    logic           write;
    rv32i_mem_wmask be;
    rv32i_word      addr;
    rv32i_word      wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_responder_array.sv
// Word storage for mem_responder: synchronous byte-lane write, combinational read.
module mem_array
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           we,
  input  rv32i_mem_wmask                 be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  rv32i_word                      wdata,
  output rv32i_word                      rdata_c
);

  rv32i_word mem [DEPTH_WORDS];

  // No reset: contents stay undefined until written
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata_c = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder (IDLE -> WAIT -> RESP). Optional sticky
// alignment/opcode error flag enabled by defining MEM_ALIGN_CHECK_EN.
module mem_responder
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mem_read,
  input  logic           mem_write,
  input  rv32i_mem_wmask mem_byte_enable,
  input  rv32i_word      mem_address,
  input  rv32i_word      mem_wdata,
  output logic           mem_resp,
  output rv32i_word      mem_rdata,
  output logic           mem_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  mem_resp_state_t        state_q, state_d;
  logic [MEM_CNT_W-1:0]   cnt_q, cnt_d;
  mem_req_t               req_q, req_d;
  logic                   resp_d;
  rv32i_word              rdata_d;
  logic                   req_c;
  logic                   arr_we_c;
  logic [AW-1:0]          arr_idx_c;
  rv32i_word              arr_rdata_c;

  assign req_c = mem_read | mem_write;

  // In IDLE the array is addressed straight from the bus so LATENCY=1 reads work
  assign arr_idx_c = (state_q == MEM_IDLE) ? mem_address[AW+1:2] : req_q.addr[AW+1:2];
  assign arr_we_c  = (state_q == MEM_RESP) && req_q.write;

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_mem_array (
    .clk     (clk),
    .we      (arr_we_c),
    .be      (req_q.be),
    .idx     (arr_idx_c),
    .wdata   (req_q.wdata),
    .rdata_c (arr_rdata_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MEM_IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      mem_resp  <= resp_d;
      mem_rdata <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    resp_d  = 1'b0;
    rdata_d = mem_rdata;

    unique case (state_q)
      MEM_IDLE: begin
        if (req_c) begin
          req_d = '{write: mem_write, be: mem_byte_enable,
                    addr: mem_address, wdata: mem_wdata};
          if (LATENCY <= 1) begin
            state_d = MEM_RESP;
          end else begin
            state_d = MEM_WAIT;
            cnt_d   = MEM_CNT_W'(LATENCY - 1);
          end
        end
      end
      MEM_WAIT: begin
        if (cnt_q <= MEM_CNT_W'(1)) begin
          state_d = MEM_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - 1'b1;
        end
      end
      MEM_RESP: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase

    // Response register loads on RESP entry so mem_resp lines up with the RESP cycle
    if (state_d == MEM_RESP && state_q != MEM_RESP) begin
      resp_d = 1'b1;
      if (!req_d.write) rdata_d = arr_rdata_c;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic err_d;

  always_comb begin
    err_d = mem_err;
    if (state_q == MEM_IDLE && req_c &&
        (mem_address[1:0] != 2'b00 || (mem_read && mem_write))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_err <= 1'b0;
    else        mem_err <= err_d;
  end
`else
  assign mem_err = 1'b0;
`endif

  logic unused_addr;
  assign unused_addr = ^{mem_address[31:AW+2], mem_address[1:0],
                         req_q.addr[31:AW+2], req_q.addr[1:0]};

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a transaction-level reference model
// and a per-cycle output compare.
module tb_mem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;
  localparam int          NEVER = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  mem_byte_enable = 4'h0;
  logic [31:0] mem_address = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        mem_err;

  mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .mem_err         (mem_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] mdata [DEPTH];
  int          exp_cyc = -1;
  logic        p_wr = 1'b0;
  int          p_idx = 0;
  logic [3:0]  p_be = 4'h0;
  logic [31:0] p_wd = 32'h0;
  logic [31:0] p_rdata = 32'h0;
  logic [31:0] hold = 32'h0;
  int          err_from = NEVER;
  int          obs_resp_cyc = -1;
  logic [31:0] obs_rdata = 32'h0;
  logic        due;
  logic        exp_err;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_resp", 32'(mem_resp), 32'h0);
      chk("rst_rdata", mem_rdata, 32'h0);
      chk("rst_err", 32'(mem_err), 32'h0);
    end else begin
      due = (cyc == exp_cyc);
      chk("resp", 32'(mem_resp), 32'(due));
      if (due) begin
        obs_resp_cyc = cyc;
        if (p_wr) begin
          for (int b = 0; b < 4; b++)
            if (p_be[b]) mdata[p_idx][8*b +: 8] = p_wd[8*b +: 8];
        end else begin
          hold = p_rdata;
        end
        obs_rdata = mem_rdata;
        exp_cyc = -1;
      end
      chk("rdata", mem_rdata, hold);
`ifdef MEM_ALIGN_CHECK_EN
      exp_err = (cyc >= err_from);
`else
      exp_err = 1'b0;
`endif
      chk("err", 32'(mem_err), 32'(exp_err));
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge following mem_resp
  task automatic req(input logic rd, input logic wr, input logic [3:0] be,
                     input logic [31:0] addr, input logic [31:0] wd);
    mem_read = rd;
    mem_write = wr;
    mem_byte_enable = be;
    mem_address = addr;
    mem_wdata = wd;
    exp_cyc = cyc + LAT;
    p_wr = wr;
    p_idx = int'((addr >> 2) % DEPTH);
    p_be = be;
    p_wd = wd;
    p_rdata = mdata[p_idx];
    if (addr[1:0] != 2'b00 || (rd && wr)) begin
      if (err_from > cyc + 1) err_from = cyc + 1;
    end
    repeat (LAT + 1) @(posedge clk);
    #1;
  endtask

  task automatic drop();
    mem_read = 1'b0;
    mem_write = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    exp_cyc = -1;
    hold = 32'h0;
    err_from = NEVER;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int k;
  int r1;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drop();

    // Latency and data of a plain read
    req(1'b0, 1'b1, 4'hF, 32'h0000_0010, 32'hCAFE_F00D); drop();
    k = cyc;
    req(1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
    chk("lat_read", 32'(obs_resp_cyc - k), 32'd2);
    chk("read_0x10", obs_rdata, 32'hCAFE_F00D);
    drop();

    // Byte-lane merge, then an all-disabled write
    req(1'b0, 1'b1, 4'hF, 32'h0000_0020, 32'hDEAD_BEEF); drop();
    req(1'b0, 1'b1, 4'h1, 32'h0000_0020, 32'h0000_00AA); drop();
    req(1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0); drop();
    chk("merge_0x20", obs_rdata, 32'hDEAD_BEAA);
    req(1'b0, 1'b1, 4'h0, 32'h0000_0020, 32'hFFFF_FFFF); drop();
    req(1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0); drop();
    chk("be0_0x20", obs_rdata, 32'hDEAD_BEAA);

    // Address wrap past DEPTH words
    req(1'b0, 1'b1, 4'hF, 32'h0000_0400, 32'h1234_5678); drop();
    req(1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0); drop();
    chk("wrap_0x0", obs_rdata, 32'h1234_5678);

    // Read+write together behaves as a write and leaves mem_rdata alone
    req(1'b1, 1'b1, 4'hF, 32'h0000_0030, 32'h55AA_55AA); drop();
    chk("prio_hold", mem_rdata, 32'h1234_5678);
    req(1'b1, 1'b0, 4'h0, 32'h0000_0030, 32'h0); drop();
    chk("prio_0x30", obs_rdata, 32'h55AA_55AA);

    // Back-to-back: write then read with no gap, then the read held over
    req(1'b0, 1'b1, 4'hF, 32'h0000_0044, 32'h0BAD_CAFE);
    req(1'b1, 1'b0, 4'h0, 32'h0000_0044, 32'h0);
    chk("raw_0x44", obs_rdata, 32'h0BAD_CAFE);
    r1 = obs_resp_cyc;
    req(1'b1, 1'b0, 4'h0, 32'h0000_0044, 32'h0);
    chk("b2b_gap", 32'(obs_resp_cyc - r1), 32'd3);
    drop();

    // Reset during the WAIT of a write aborts it
    req(1'b0, 1'b1, 4'hF, 32'h0000_0040, 32'h1111_1111); drop();
    mem_write = 1'b1;
    mem_byte_enable = 4'hF;
    mem_address = 32'h0000_0040;
    mem_wdata = 32'h2222_2222;
    @(posedge clk);
    #1;
    do_reset(3);
    drop();
    req(1'b1, 1'b0, 4'h0, 32'h0000_0040, 32'h0); drop();
    chk("abort_0x40", obs_rdata, 32'h1111_1111);
    chk("err_clear", 32'(mem_err), 32'h0);

    // Misaligned read completes normally; error flag depends on the build
    req(1'b1, 1'b0, 4'h0, 32'h0000_0013, 32'h0); drop();
    chk("misalign_data", obs_rdata, 32'hCAFE_F00D);
    repeat (3) @(posedge clk);
    #1;
`ifdef MEM_ALIGN_CHECK_EN
    chk("misalign_err", 32'(mem_err), 32'h1);
`else
    chk("misalign_err", 32'(mem_err), 32'h0);
`endif
    do_reset(2);
    drop();
    chk("err_after_rst", 32'(mem_err), 32'h0);
    chk("rdata_after_rst", mem_rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, storage depth in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to mem_resp (legal range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_read  input  1  read request, held by initiator until mem_resp.
REQ-006 SHALL have port mem_write  input  1  write request, held by initiator until mem_resp.
REQ-007 SHALL have port mem_byte_enable  input  4  write byte-lane mask (rv32i_mem_wmask), bit i enables byte i.
REQ-008 SHALL have port mem_address  input  32  byte address.
REQ-009 SHALL have port mem_wdata  input  32  write data (rv32i_word).
REQ-010 SHALL have port mem_resp  output  1  one-cycle completion pulse.
REQ-011 SHALL have port mem_rdata  output  32  read data, valid while mem_resp high.
REQ-012 SHALL have port mem_err  output  1  sticky protocol/alignment error flag.

Function
REQ-013 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-014 IDLE: on mem_read|mem_write SHALL capture address, wdata, byte_enable, opcode; go WAIT (or RESP directly if LATENCY=1).
REQ-015 WAIT: SHALL count down LATENCY-1 cycles, then go RESP; inputs ignored while in WAIT.
REQ-016 Request high in IDLE during cycle c SHALL yield mem_resp high in exactly cycle c+LATENCY, for one cycle only.
REQ-017 RESP: read SHALL drive mem_rdata = stored word; write SHALL commit only enabled bytes at the RESP-exit edge.
REQ-018 mem_rdata SHALL hold last read value until the next read response; writes SHALL not change it.
REQ-019 Request still high in the cycle after RESP SHALL be accepted as a new request (back-to-back, no dead cycle beyond RESP).
REQ-020 mem_read and mem_write both high at acceptance: write SHALL take priority; read ignored.
REQ-021 Word index = mem_address[log2(DEPTH_WORDS)+1:2]; upper bits ignored (address wrap-around).
REQ-022 Write with mem_byte_enable = 4'b0000 SHALL complete with mem_resp and leave storage unchanged.
REQ-023 Read of a word written in the immediately preceding transaction SHALL return the new data.

Reset
REQ-024 rst_n low SHALL force IDLE, counter 0, mem_resp 0, mem_rdata 0, mem_err 0 asynchronously.
REQ-025 Reset mid-transaction SHALL abort it: no mem_resp, pending write not committed.
REQ-026 Storage array SHALL not be cleared by reset; contents undefined until written.

Configuration
REQ-027 Macro MEM_ALIGN_CHECK_EN defined: accepted request with mem_address[1:0] != 0, or read and write both high, SHALL set mem_err until reset; transaction still completes normally.
REQ-028 MEM_ALIGN_CHECK_EN undefined: mem_err SHALL be tied 0; no check logic present.

Structure
REQ-029 Package rv32i_types SHALL hold the FSM state enum mem_resp_state_t and constant MEM_LATENCY_MAX = 15; rv32i_word and rv32i_mem_wmask reused from it.
REQ-030 Storage SHALL be a sub-module mem_array: DEPTH_WORDS x 32, synchronous byte-lane write, combinational read.

Verification
REQ-031 LATENCY=2: read 0x0000_0010 asserted cycle 5 -> mem_resp only in cycle 7, with data previously written there.
REQ-032 Write 0xDEADBEEF to 0x20 mask 4'b1111, then write 0x000000AA mask 4'b0001, read 0x20 -> 0xDEADBEAA.
REQ-033 DEPTH_WORDS=256: write 0x12345678 to 0x0000_0400, read 0x0000_0000 -> 0x12345678 (wrap).
REQ-034 rst_n low during WAIT of write to 0x40 -> no mem_resp; subsequent read of 0x40 returns prior contents; outputs 0 during reset.
REQ-035 Back-to-back: read held one cycle past mem_resp -> second mem_resp exactly LATENCY+1 cycles after first.
REQ-036 MEM_ALIGN_CHECK_EN defined: read 0x0000_0013 -> mem_resp normal, mem_err rises and stays 1 until rst_n low; undefined -> mem_err stays 0.
